// File: rtl/register_file.sv
// register_file: 32 x 32-bit general-purpose register file.
//   Two independent combinational read ports, one synchronous write port.
//   Every index, including 0, is an ordinary writable register.
//
// Ports:
//   clk              in   1   rising-edge write clock
//   rst              in   1   asynchronous active-low reset; clears all registers
//   readReg_1        in   5   read port 1 index
//   readReg_2        in   5   read port 2 index
//   writeReg         in   5   write port index
//   writeData        in   32  write data
//   control_RegWrite in   1   write enable, active-high
//   readData1        out  32  contents of register readReg_1 (combinational)
//   readData2        out  32  contents of register readReg_2 (combinational)
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  readReg_1,
  input  logic [4:0]  readReg_2,
  input  logic [4:0]  writeReg,
  input  logic [31:0] writeData,
  input  logic        control_RegWrite,
  output logic [31:0] readData1,
  output logic [31:0] readData2
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: async clear dominates, so writes are ignored while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (control_RegWrite) begin
      regs[writeReg] <= writeData;
    end
  end

  // Reads see stored state only; a pending write appears after its edge.
  assign readData1 = regs[readReg_1];
  assign readData2 = regs[readReg_2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  readReg_1;
  logic [4:0]  readReg_2;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        control_RegWrite;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk              (clk),
    .rst              (rst),
    .readReg_1        (readReg_1),
    .readReg_2        (readReg_2),
    .writeReg         (writeReg),
    .writeData        (writeData),
    .control_RegWrite (control_RegWrite),
    .readData1        (readData1),
    .readData2        (readData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic edge_and_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    control_RegWrite = 1'b0;
    readReg_1 = 5'd0;
    readReg_2 = 5'd0;
    writeReg  = 5'd0;
    writeData = 32'd0;

    // Reset then read
    #3;
    rst = 1'b0;
    readReg_1 = 5'd5;
    readReg_2 = 5'd8;
    #1;
    check("reset_rd1_idx5", readData1, 32'd0);
    check("reset_rd2_idx8", readData2, 32'd0);

    // Write attempted while in reset is ignored
    control_RegWrite = 1'b1;
    writeReg  = 5'd8;
    writeData = 32'd1298;
    edge_and_settle();
    check("write_in_reset_ignored", readData2, 32'd0);

    // Release reset, write disabled
    @(negedge clk);
    rst = 1'b1;
    control_RegWrite = 1'b0;
    writeReg  = 5'd8;
    writeData = 32'd455;
    edge_and_settle();
    check("we0_idx8_stays0", readData2, 32'd0);

    // Write then read; no bypass before edge
    @(negedge clk);
    control_RegWrite = 1'b1;
    writeData = 32'd1298;
    #1;
    check("no_bypass_before_edge", readData2, 32'd0);
    edge_and_settle();
    check("write8_rd2", readData2, 32'd1298);

    @(negedge clk);
    writeReg  = 5'd5;
    writeData = 32'd5111;
    edge_and_settle();
    check("write5_rd1", readData1, 32'd5111);
    check("idx8_holds", readData2, 32'd1298);

    // Combinational index change, then overwrite
    @(negedge clk);
    readReg_1 = 5'd8;
    readReg_2 = 5'd17;
    #1;
    check("comb_index_rd1", readData1, 32'd1298);
    check("comb_index_rd2", readData2, 32'd0);
    writeReg  = 5'd17;
    writeData = 32'd8649130;
    edge_and_settle();
    check("write17_first", readData2, 32'd8649130);
    @(negedge clk);
    writeData = 32'd45611;
    edge_and_settle();
    check("write17_overwrite", readData2, 32'd45611);
    check("idx8_after_overwrite", readData1, 32'd1298);

    // Same index on both ports
    @(negedge clk);
    control_RegWrite = 1'b0;
    readReg_1 = 5'd17;
    #1;
    check("same_idx_rd1", readData1, 32'd45611);
    check("same_idx_rd2", readData2, 32'd45611);

    // Register 0 is writable; full width stored
    @(negedge clk);
    control_RegWrite = 1'b1;
    writeReg  = 5'd0;
    writeData = 32'hFFFF_FFFF;
    readReg_1 = 5'd0;
    edge_and_settle();
    check("reg0_full_width", readData1, 32'hFFFF_FFFF);
    check("idx17_untouched", readData2, 32'd45611);

    // Back-to-back writes to one index keep the last
    readReg_1 = 5'd3;
    @(negedge clk);
    writeReg  = 5'd3;
    writeData = 32'hA5A5_0001;
    edge_and_settle();
    @(negedge clk);
    writeData = 32'h8000_0002;
    edge_and_settle();
    @(negedge clk);
    writeData = 32'h1234_5678;
    #1;
    check("old_value_before_edge", readData1, 32'h8000_0002);
    edge_and_settle();
    check("b2b_last_value", readData1, 32'h1234_5678);

    // Write disabled with new data leaves register alone
    @(negedge clk);
    control_RegWrite = 1'b0;
    writeData = 32'hDEAD_BEEF;
    edge_and_settle();
    check("we0_idx3_holds", readData1, 32'h1234_5678);

    // Reset mid-operation clears immediately
    @(negedge clk);
    readReg_1 = 5'd8;
    readReg_2 = 5'd17;
    #1;
    check("pre_reset_idx8", readData1, 32'd1298);
    #1;
    rst = 1'b0;
    #1;
    check("midreset_rd1", readData1, 32'd0);
    check("midreset_rd2", readData2, 32'd0);
    control_RegWrite = 1'b1;
    writeReg  = 5'd8;
    writeData = 32'd1298;
    edge_and_settle();
    edge_and_settle();
    check("reset_hold_idx8", readData1, 32'd0);

    // Release and first write works
    @(negedge clk);
    rst = 1'b1;
    writeReg  = 5'd17;
    writeData = 32'd9876;
    edge_and_settle();
    check("release_write17", readData2, 32'd9876);
    check("release_idx8_zero", readData1, 32'd0);
    @(negedge clk);
    control_RegWrite = 1'b0;
    readReg_1 = 5'd0;
    readReg_2 = 5'd3;
    #1;
    check("reg0_cleared", readData1, 32'd0);
    check("reg3_cleared", readData2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
